// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared 7-segment glyph constants and the nibble-to-glyph mapping.
//            All glyphs are active-low over {a,b,c,d,e,f,g} = seg[6:0].
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b1110010;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex nibble to active-low glyph (lowercase b, c, d for legibility).
    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        logic [6:0] glyph;
        case (nib)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// ============================================================================
// Module   : seg7_glyph
// Brief    : Combinational hex nibble to active-low 7-segment glyph decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure lookup; the scan driver registers the result.
    always_comb begin
        o_seg = nibble_to_seg(i_nibble);
    end

endmodule : seg7_glyph
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed driver for NUM_DIGITS common-anode 7-segment
//            digits with per-digit decimal points, leading-zero blanking,
//            anti-ghosting dead time and frame-aligned (tear-free) updates.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    // Pending set (written by load) and shadow set (drives the display)
    logic [4*NUM_DIGITS-1:0] r_pd_value;
    logic [NUM_DIGITS-1:0]   r_pd_dp;
    logic                    r_pd_lzb;
    logic                    r_pend;
    logic [4*NUM_DIGITS-1:0] r_sh_value;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_sh_lzb;

    // Registered outputs
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_tick;

    logic                    w_cnt_last;
    logic                    w_boundary;
    logic                    w_dead;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic                    w_dp_req;
    logic [6:0]              w_glyph;

    assign w_cnt_last = (r_cnt == C_CNT_LAST);
    assign w_boundary = w_cnt_last && (r_idx == C_IDX_LAST);

    // Dead time only exists when DEAD_CYCLES is non-zero; avoids a
    // constant-false unsigned compare in the zero case.
    generate
        if (DEAD_CYCLES > 0) begin : g_dead
            assign w_dead = (r_cnt < CNT_W'(DEAD_CYCLES));
        end else begin : g_no_dead
            assign w_dead = 1'b0;
        end
    endgenerate

    // Slot counter and digit index; idx advances when cnt wraps.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Pending capture and frame-boundary transfer into the shadow set.
    // A load on the boundary edge stays pending for the following frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pd_value <= '0;
            r_pd_dp    <= '0;
            r_pd_lzb   <= 1'b0;
            r_pend     <= 1'b0;
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_lzb   <= 1'b0;
        end else begin
            if (w_boundary && r_pend) begin
                r_sh_value <= r_pd_value;
                r_sh_dp    <= r_pd_dp;
                r_sh_lzb   <= r_pd_lzb;
            end
            if (load) begin
                r_pd_value <= value;
                r_pd_dp    <= dp_in;
                r_pd_lzb   <= lzb_en;
                r_pend     <= 1'b1;
            end else if (w_boundary) begin
                r_pend     <= 1'b0;
            end
        end
    end

    // Leading-zero map: digit k blanks when it and every higher nibble are 0.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run & (r_sh_value[4*k +: 4] == 4'h0);
            if (k != 0) begin
                w_lz[k] = r_sh_lzb & w_zero_run;
            end
        end
    end

    // Select the nibble, blank flag and dp request of the active digit.
    always_comb begin
        w_nib    = 4'h0;
        w_blank  = 1'b0;
        w_dp_req = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib    = r_sh_value[4*k +: 4];
                w_blank  = w_lz[k];
                w_dp_req = r_sh_dp[k];
            end
        end
    end

    seg7_glyph u_glyph (
        .i_nibble (w_nib),
        .o_seg    (w_glyph)
    );

    // Output register: dead time forces everything off, else drive the digit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_an         <= '1;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            if (w_dead) begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg <= w_blank ? SEG_BLANK : w_glyph;
                r_dp  <= ~w_dp_req;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Self-checking bench for seg7_scan_driver (4 digits, 4-cycle
//            slots, 1 dead cycle) against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int D     = 1;
    localparam int FRAME = N * R;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          lzb_en = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_tick;

    seg7_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .DEAD_CYCLES (D)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: edges since reset release plus the two value sets.
    int          m_edges = 0;
    int          cur_p   = -1;
    bit          m_pend  = 0;
    logic [15:0] m_pv = '0, m_sv = '0;
    logic [3:0]  m_pdp = '0, m_sdp = '0;
    bit          m_plzb = 0, m_slzb = 0;
    logic [3:0]  exp_an  = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp  = 1'b1;
    logic        exp_ft  = 1'b0;
    bit          chk_en  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic tick();
        int p, di, cnt;
        @(posedge clk);
        if (!resetn) begin
            m_edges = 0; cur_p = -1; m_pend = 0;
            m_pv = '0; m_sv = '0; m_pdp = '0; m_sdp = '0; m_plzb = 0; m_slzb = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
        end else begin
            p   = m_edges % FRAME;
            di  = p / R;
            cnt = p % R;
            cur_p = p;
            if (cnt < D) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an  = 4'hF ^ (4'h1 << di);
                exp_seg = (m_slzb && di != 0 && (m_sv >> (4*di)) == 16'h0)
                          ? 7'h7F : glyph[(m_sv >> (4*di)) & 16'hF];
                exp_dp  = ~m_sdp[di];
            end
            exp_ft = ((m_edges + 1) % FRAME == 0);
            if (p == FRAME - 1 && m_pend) begin
                m_sv = m_pv; m_sdp = m_pdp; m_slzb = m_plzb; m_pend = 0;
            end
            if (load) begin
                m_pv = value; m_pdp = dp_in; m_plzb = lzb_en; m_pend = 1;
            end
            m_edges++;
        end
        #1;
    endtask

    // Compare every cycle, mid-period, once the model is initialised.
    always @(negedge clk) begin
        if (chk_en) begin
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
            check("dp", 32'(dp), 32'(exp_dp));
            check("frame_tick", 32'(frame_tick), 32'(exp_ft));
        end
    end

    task automatic wait_pos(input int target);
        int k;
        k = 0;
        tick();
        while (cur_p != target && k < 40) begin
            tick();
            k++;
        end
        if (cur_p != target) check("wait_pos_timeout", 32'(cur_p), 32'(target));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input bit z);
        load = 1'b1; value = v; dp_in = d; lzb_en = z;
        tick();
        load = 1'b0;
    endtask

    initial begin : main
        int k;
        // 1. Reset
        resetn = 1'b0;
        tick(); chk_en = 1;
        tick(); tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_ft", 32'(frame_tick), 32'h0);
        resetn = 1'b1;
        tick();
        check("cyc1_an", 32'(an), 32'hF);
        tick();
        check("cyc2_an", 32'(an), 32'hE);
        k = 2;
        while (frame_tick !== 1'b1 && k < 40) begin tick(); k++; end
        check("first_tick_cycle", 32'(k), 32'd16);

        // 2. Full hex scan
        wait_pos(3);
        do_load(16'hC9A5, 4'b0010, 1'b0);
        wait_pos(15);
        wait_pos(1);  check("hex_d0", 32'(seg), 32'b0100100);
        check("hex_d0_dp", 32'(dp), 32'h1);
        wait_pos(5);  check("hex_d1", 32'(seg), 32'b0001000);
        check("hex_d1_dp", 32'(dp), 32'h0);
        check("hex_d1_an", 32'(an), 32'b1101);
        wait_pos(9);  check("hex_d2", 32'(seg), 32'b0000100);
        wait_pos(13); check("hex_d3", 32'(seg), 32'b1110010);

        // 3. Leading-zero blanking
        do_load(16'h0040, 4'b0000, 1'b1);
        wait_pos(15);
        wait_pos(1);  check("lzb_d0", 32'(seg), 32'b0000001);
        wait_pos(5);  check("lzb_d1", 32'(seg), 32'b1001100);
        wait_pos(9);  check("lzb_d2", 32'(seg), 32'h7F);
        check("lzb_d2_an", 32'(an), 32'b1011);
        wait_pos(13); check("lzb_d3", 32'(seg), 32'h7F);
        check("lzb_d3_an", 32'(an), 32'b0111);
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_pos(15);
        wait_pos(1);  check("zero_d0", 32'(seg), 32'b0000001);
        wait_pos(5);  check("zero_d1", 32'(seg), 32'h7F);

        // 4. Tear-free update: two loads mid-frame, last one wins next frame
        do_load(16'h1111, 4'b0000, 1'b0);
        tick();
        do_load(16'h2222, 4'b0000, 1'b0);
        wait_pos(13); check("tear_old_d3", 32'(seg), 32'h7F);
        wait_pos(1);  check("tear_new_d0", 32'(seg), 32'b0010010);
        wait_pos(13); check("tear_new_d3", 32'(seg), 32'b0010010);

        // 5. Boundary-coincident load
        wait_pos(14);
        do_load(16'h3333, 4'b0000, 1'b0);
        check("bnd_load_pos", 32'(cur_p), 32'd15);
        wait_pos(1);  check("bnd_still_old", 32'(seg), 32'b0010010);
        wait_pos(15);
        wait_pos(1);  check("bnd_new", 32'(seg), 32'b0000110);

        // 6. Dead time and mid-frame reset
        wait_pos(4);  check("dead_an", 32'(an), 32'hF);
        tick();       check("live_an", 32'(an), 32'b1101);
        do_load(16'h5555, 4'b1111, 1'b0);
        wait_pos(9);
        resetn = 1'b0;
        tick();
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        resetn = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) tick();
        wait_pos(1);  check("lost_load_d0", 32'(seg), 32'b0000001);
        check("lost_load_dp", 32'(dp), 32'h1);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            load   = ($urandom_range(0, 7) == 0);
            value  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
            dp_in  = 4'($urandom);
            lzb_en = 1'($urandom);
            resetn = ($urandom_range(0, 299) != 0);
            tick();
        end
        resetn = 1'b1;
        load   = 1'b0;
        tick();
        chk_en = 0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment digits. It generalises the single-digit hex decoder to NUM_DIGITS digits with a refresh counter and per-digit decimal points. It adds optional leading-zero blanking, an anti-ghosting dead time and tear-free value updates at frame boundaries. It sits between the datapath, which supplies a packed hex value, and the board display pins.

## Interface

Parameters:
- NUM_DIGITS, 4: digits driven, legal 1..8.
- REFRESH_DIV, 50000: clock cycles each digit is selected, ≥2.
- DEAD_CYCLES, 2: cycles at the start of each digit slot with all outputs off, 0..REFRESH_DIV-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- load  in  1  one-cycle strobe: capture value/dp_in/lzb_en.
- value  in  4*NUM_DIGITS  hex nibbles, digit 0 = value[3:0] (least significant).
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- lzb_en  in  1  leading-zero blanking enable.
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit select, active-low, at most one low.
- frame_tick  out  1  one-cycle pulse when digit 0 slot begins.

## Operation

- Glyphs are active-low over abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - c=1110010, d=1000010, E=0110000, F=0111000
- Blank glyph: 1111111.
- Three register sets:
  - pending: value, dp, lzb and a pend flag.
  - shadow: drives the display.
  - scan state: slot counter cnt and digit index idx.
- load=1: pending ← inputs, pend ← 1. Several loads before a boundary: the last one wins.
- Frame boundary is cnt=REFRESH_DIV-1 with idx=NUM_DIGITS-1. At the boundary, if pend is 1 (value as registered before this edge), shadow ← pending and pend ← 0.
- A load coincident with the boundary lands in pending and is applied at the next boundary.
- Scan:
  - cnt counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, idx increments modulo NUM_DIGITS.
- Leading-zero blanking, evaluated on shadow: digit k is blanked when lzb is set, every nibble from k through NUM_DIGITS-1 is 0, and k≠0. Digit 0 is never blanked. dp is unaffected by blanking.
- Slot output:
  - cnt < DEAD_CYCLES: an all-1, seg=1111111, dp=1.
  - Otherwise: an = ~(1<<idx); seg is the glyph of nibble idx, or blank if blanked; dp = ~shadow_dp[idx].
- frame_tick: high for exactly one cycle when idx becomes 0 and cnt becomes 0.

## Timing

- Reset values: cnt=0, idx=0, pend=0, shadow and pending all 0, an all-1, seg=1111111, dp=1, frame_tick=0.
- Outputs are registered: they reflect the cnt/idx present one cycle earlier.
- First display after reset:
  - The first cycle after reset release starts the digit-0 slot. frame_tick is not asserted for this post-reset start; it first pulses at the next frame start, NUM_DIGITS*REFRESH_DIV cycles later.
  - an goes low for digit 0 at cycle DEAD_CYCLES+1 after reset release.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-visible latency is between 1 cycle and one full frame, plus DEAD_CYCLES+1.
- resetn low mid-frame: the next edge forces all reset values. The pending load is discarded.
- No handshake back-pressure: load is always accepted.

## Structure

- Package seg7_pkg holds:
  - the 16 glyph localparams and SEG_BLANK=7'b1111111;
  - function nibble_to_seg.
- Sub-module seg7_glyph: combinational nibble→seg. Instantiated once, on the muxed nibble.
- Counter widths: $clog2(REFRESH_DIV) for cnt, $clog2(NUM_DIGITS) (min 1) for idx.

## Test plan

Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.

1. **Reset:** hold resetn=0 for 3 cycles → an=1111, seg=1111111, dp=1, frame_tick=0. After release, an=1110 at cycle 2 and frame_tick first pulses 16 cycles after release.
2. **Full hex scan:** load value=0xC9A5, dp_in=0010, lzb_en=0 → after the boundary, slots show seg:
   - idx0=0100100, idx1=0001000, idx2=0000100, idx3=1110010
   - dp low only while an=1101.
3. **Leading-zero blanking:** load 0x0040, lzb_en=1 → digits 3 and 2 show 1111111 with their an low; digit 1=1001100; digit 0=0000001. Load 0x0000 → only digit 0 lit, showing 0000001.
4. **Tear-free update:** load 0x1111 mid-frame, then 0x2222 two cycles later → the current frame keeps its old value; the next frame shows only 0010010 on all digits.
5. **Boundary-coincident load:** assert load on the boundary edge → the new value appears one frame later; pend is cleared at that later boundary.
6. **Dead time and mid-frame reset:** check an=1111 for exactly 1 cycle per slot. Assert resetn=0 during idx=2 → outputs return to reset values next edge; the pending load is lost.
